// File: rtl/frv_asi_ctrl_if.sv
// Purpose: bundles the decode, frv_asi and writeback handshakes of the ASI issue/response stage.
// Latency: none, wiring only.
// Backpressure: carries s_valid/s_ready, asi_valid/asi_ready and m_valid/m_ready unchanged.
interface frv_asi_ctrl_if #(
  parameter int XLEN = 32,
  parameter int OP   = 4
);
  // decode side
  logic            s_valid;
  logic            s_ready;
  logic [OP:0]     s_uop;
  logic [XLEN-1:0] s_rs1;
  logic [XLEN-1:0] s_rs2;
  logic [1:0]      s_shamt;
  logic [4:0]      s_rd;
  // pipeline control
  logic            kill;
  logic            ctx_flush;
  logic [31:0]     ctx_flush_data;
  // frv_asi side
  logic            asi_valid;
  logic            asi_ready;
  logic [OP:0]     asi_uop;
  logic [XLEN-1:0] asi_rs1;
  logic [XLEN-1:0] asi_rs2;
  logic [1:0]      asi_shamt;
  logic [XLEN-1:0] asi_result;
  logic            asi_flush_aessub;
  logic            asi_flush_aesmix;
  logic [31:0]     asi_flush_data;
  // writeback side
  logic            m_valid;
  logic            m_ready;
  logic [XLEN-1:0] m_result;
  logic [4:0]      m_rd;
  logic            m_err;

  // the issue/response controller
  modport slave (
    input  s_valid, s_uop, s_rs1, s_rs2, s_shamt, s_rd,
    input  kill, ctx_flush, ctx_flush_data,
    input  asi_ready, asi_result, m_ready,
    output s_ready, asi_valid, asi_uop, asi_rs1, asi_rs2, asi_shamt,
    output asi_flush_aessub, asi_flush_aesmix, asi_flush_data,
    output m_valid, m_result, m_rd, m_err
  );

  // the surrounding pipeline (decode, frv_asi, writeback)
  modport master (
    output s_valid, s_uop, s_rs1, s_rs2, s_shamt, s_rd,
    output kill, ctx_flush, ctx_flush_data,
    output asi_ready, asi_result, m_ready,
    input  s_ready, asi_valid, asi_uop, asi_rs1, asi_rs2, asi_shamt,
    input  asi_flush_aessub, asi_flush_aesmix, asi_flush_data,
    input  m_valid, m_result, m_rd, m_err
  );
endinterface

// File: rtl/frv_asi_ctrl.sv
// Purpose: issue/response stage around frv_asi; owns kill, context flush and watchdog abort.
// Latency: accept edge -> m_valid after the next edge when frv_asi answers in one cycle.
// Backpressure: result held in DONE until m_ready; s_ready low while BUSY or result stalled.
module frv_asi_ctrl #(
  parameter int XLEN       = 32,
  parameter int OP         = 4,
  parameter int TIMEOUT    = 15,
  parameter int TIMEOUT_EN = 1
) (
  input logic           g_clk,
  input logic           g_resetn,
  frv_asi_ctrl_if.slave bus
);
  localparam int XL = XLEN - 1;
  // uop[OP:OP-1] is the instruction class; 2'b01 is AES, where uop[2] picks mix over sub
  localparam logic [1:0] CLASS_AES = 2'b01;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [OP:0]  uop_q;
  logic [XL:0]  rs1_q, rs2_q;
  logic [1:0]   shamt_q;
  logic [4:0]   rd_q;
  logic [7:0]   cnt_q;
  logic [7:0]   cnt_inc;
  logic [XL:0]  result_q;
  logic [4:0]   m_rd_q;
  logic         err_q;
  logic         fl_sub_q, fl_mix_q, fl_sub_d, fl_mix_d;
  logic [31:0]  fl_data_q, fl_data_d;

  logic busy, held_aes, abort, accept, stall, timeout, pulse_ok;

  assign busy     = (state_q == BUSY);
  assign held_aes = (uop_q[OP -: 2] == CLASS_AES);
  assign abort    = bus.kill | bus.ctx_flush;
  // nothing is accepted while held in reset or while a flush/kill is being applied
  assign bus.s_ready = g_resetn & ~abort &
                       ((state_q == IDLE) | ((state_q == DONE) & bus.m_ready));
  assign accept   = bus.s_valid & bus.s_ready;
  assign stall    = busy & ~bus.asi_ready;
  assign cnt_inc  = cnt_q + 8'd1;
  // the abort fires on the stall cycle that brings the count to TIMEOUT
  assign timeout  = (TIMEOUT_EN != 0) && stall && (cnt_inc == 8'(TIMEOUT));
  // a new pulse never follows a pulse directly, so flush lines are never high twice in a row
  assign pulse_ok = ~(fl_sub_q | fl_mix_q);

  // operands reach frv_asi only from the held registers, and only while BUSY
  assign bus.asi_valid        = busy;
  assign bus.asi_uop          = busy ? uop_q   : '0;
  assign bus.asi_rs1          = busy ? rs1_q   : '0;
  assign bus.asi_rs2          = busy ? rs2_q   : '0;
  assign bus.asi_shamt        = busy ? shamt_q : '0;
  assign bus.asi_flush_aessub = fl_sub_q;
  assign bus.asi_flush_aesmix = fl_mix_q;
  assign bus.asi_flush_data   = fl_data_q;
  assign bus.m_valid          = (state_q == DONE);
  assign bus.m_result         = result_q;
  assign bus.m_rd             = m_rd_q;
  assign bus.m_err            = err_q;

  // state and registered flush pulses
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= IDLE;
      fl_sub_q  <= 1'b0;
      fl_mix_q  <= 1'b0;
      fl_data_q <= '0;
    end else begin
      state_q   <= state_d;
      fl_sub_q  <= fl_sub_d;
      fl_mix_q  <= fl_mix_d;
      fl_data_q <= fl_data_d;
    end
  end

  // next state and flush requests; kill > ctx_flush > watchdog > asi_ready > accept
  always_comb begin
    state_d   = state_q;
    fl_sub_d  = 1'b0;
    fl_mix_d  = 1'b0;
    fl_data_d = '0;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        if (abort)                          state_d = IDLE;
        else if (timeout || bus.asi_ready)  state_d = DONE;
      end
      DONE: begin
        if (bus.kill)          state_d = IDLE;
        else if (bus.m_ready)  state_d = accept ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pulse_ok) begin
      if (bus.kill) begin
        if (busy && held_aes) begin
          fl_sub_d = ~uop_q[2];
          fl_mix_d = uop_q[2];
        end
      end else if (bus.ctx_flush) begin
        fl_sub_d  = 1'b1;
        fl_mix_d  = 1'b1;
        fl_data_d = bus.ctx_flush_data;
      end else if (timeout && held_aes) begin
        fl_sub_d = ~uop_q[2];
        fl_mix_d = uop_q[2];
      end
    end
  end

  // operand capture, stall counter and result register
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      uop_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      shamt_q  <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      m_rd_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        uop_q   <= bus.s_uop;
        rs1_q   <= bus.s_rs1;
        rs2_q   <= bus.s_rs2;
        shamt_q <= bus.s_shamt;
        rd_q    <= bus.s_rd;
        cnt_q   <= '0;
      end else if (stall && (TIMEOUT_EN != 0)) begin
        cnt_q <= cnt_inc;
      end
      if (busy && !abort && (timeout || bus.asi_ready)) begin
        result_q <= timeout ? '0 : bus.asi_result;
        m_rd_q   <= rd_q;
        err_q    <= timeout;
      end
    end
  end
endmodule

// File: tb/tb_frv_asi_ctrl.sv
module tb_frv_asi_ctrl;
  localparam logic [4:0] UOP_AESSUB    = 5'b01000;
  localparam logic [4:0] UOP_AESMIX    = 5'b01100;
  localparam logic [4:0] UOP_SHA3_XY   = 5'b10000;
  localparam logic [4:0] UOP_SHA256_S0 = 5'b11000;
  localparam logic [4:0] UOP_SHA256_S1 = 5'b11001;

  typedef struct { logic [31:0] result; logic [4:0] rd; logic err; } resp_t;
  typedef struct { logic sub; logic mix; logic [31:0] data; } fl_t;

  logic g_clk = 1'b0;
  logic g_resetn;
  logic asi_rdy_en;
  int   checks = 0;
  int   failures = 0;
  resp_t exp_q[$];
  fl_t   fl_q[$];
  logic [4:0]  cur_uop;
  logic [31:0] cur_rs1, cur_rs2;
  logic [1:0]  cur_sh;
  logic        prev_fl = 1'b0;

  frv_asi_ctrl_if #(.XLEN(32), .OP(4)) bus();

  frv_asi_ctrl #(.XLEN(32), .OP(4), .TIMEOUT(15), .TIMEOUT_EN(1)) dut (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .bus     (bus.slave)
  );

  always #5 g_clk = ~g_clk;

  // frv_asi stub: single-cycle when enabled, result = rs1 ^ rs2 ^ shamt
  assign bus.asi_ready  = asi_rdy_en;
  assign bus.asi_result = bus.asi_rs1 ^ bus.asi_rs2 ^ {30'd0, bus.asi_shamt};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_resp(input logic [31:0] r, input logic [4:0] rd, input logic e);
    resp_t t;
    t.result = r; t.rd = rd; t.err = e;
    exp_q.push_back(t);
  endtask

  task automatic exp_flush(input logic s, input logic m, input logic [31:0] d);
    fl_t t;
    t.sub = s; t.mix = m; t.data = d;
    fl_q.push_back(t);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge g_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {bus.s_ready, bus.asi_valid, bus.m_valid, bus.m_err,
                         bus.asi_flush_aessub, bus.asi_flush_aesmix, bus.asi_shamt,
                         bus.m_rd, bus.asi_uop}, 64'd0);
    chk({name, "_res"}, {bus.m_result, bus.asi_flush_data}, 64'd0);
    chk({name, "_ops"}, {bus.asi_rs1, bus.asi_rs2}, 64'd0);
  endtask

  // offer one op; returns just after the accepting edge, with m_valid seen in that cycle
  task automatic issue(input logic [4:0] uop, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [1:0] sh, input logic [4:0] rd, output logic was_done);
    logic ok = 1'b0;
    was_done = 1'b0;
    bus.s_valid = 1'b1; bus.s_uop = uop; bus.s_rs1 = rs1; bus.s_rs2 = rs2;
    bus.s_shamt = sh;   bus.s_rd = rd;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge g_clk);
      if (bus.s_ready) begin
        ok = 1'b1;
        was_done = bus.m_valid;
      end
      @(posedge g_clk);
      #1;
    end
    chk("issue_accepted", ok, 1'b1);
    cur_uop = uop; cur_rs1 = rs1; cur_rs2 = rs2; cur_sh = sh;
    bus.s_valid = 1'b0; bus.s_uop = 5'h1f; bus.s_rs1 = 32'hA5A5_A5A5;
    bus.s_rs2 = 32'h5A5A_5A5A; bus.s_shamt = 2'd3; bus.s_rd = 5'd30;
  endtask

  task automatic wait_idle();
    logic idle = 1'b0;
    for (int n = 0; n < 60 && !idle; n++) begin
      @(negedge g_clk);
      idle = !bus.m_valid && !bus.asi_valid;
    end
    chk("reached_idle", idle, 1'b1);
    @(posedge g_clk);
    #1;
  endtask

  // monitor: responses, operand stability and flush pulses, all against queued expectations
  always @(negedge g_clk) begin
    if (bus.m_valid) begin
      chk("resp_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        chk("m_result", bus.m_result, exp_q[0].result);
        chk("m_rd", bus.m_rd, exp_q[0].rd);
        chk("m_err", bus.m_err, exp_q[0].err);
        if (bus.m_ready) void'(exp_q.pop_front());
      end
    end
    if (bus.asi_valid) begin
      chk("asi_uop_sh", {bus.asi_uop, bus.asi_shamt}, {cur_uop, cur_sh});
      chk("asi_rs", {bus.asi_rs1, bus.asi_rs2}, {cur_rs1, cur_rs2});
    end else begin
      chk("asi_idle_ops", {bus.asi_uop, bus.asi_shamt, bus.asi_rs1, bus.asi_rs2}, 64'd0);
    end
    if (bus.asi_flush_aessub || bus.asi_flush_aesmix) begin
      chk("flush_gap", prev_fl, 1'b0);
      chk("flush_expected", fl_q.size() != 0, 1'b1);
      if (fl_q.size() != 0) begin
        chk("flush_lines", {bus.asi_flush_aessub, bus.asi_flush_aesmix}, {fl_q[0].sub, fl_q[0].mix});
        chk("flush_data", bus.asi_flush_data, fl_q[0].data);
        void'(fl_q.pop_front());
      end
    end else begin
      chk("flush_data_idle", bus.asi_flush_data, 32'd0);
    end
    prev_fl = bus.asi_flush_aessub | bus.asi_flush_aesmix;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic acc_done;
    int   busy_n;
    logic found;
    g_resetn = 1'b0; asi_rdy_en = 1'b1;
    bus.s_valid = 1'b0; bus.s_uop = '0; bus.s_rs1 = '0; bus.s_rs2 = '0;
    bus.s_shamt = '0; bus.s_rd = '0; bus.kill = 1'b0; bus.ctx_flush = 1'b0;
    bus.ctx_flush_data = '0; bus.m_ready = 1'b1;
    cur_uop = '0; cur_rs1 = '0; cur_rs2 = '0; cur_sh = '0;
    #2;
    chk_all_zero("reset");
    cycles(3);
    g_resetn = 1'b1;
    @(negedge g_clk);
    chk("s_ready_after_reset", bus.s_ready, 1'b1);
    cycles(1);

    // single op latency: SHA256_S0 of zero
    exp_resp(32'h0, 5'd1, 1'b0);
    issue(UOP_SHA256_S0, 32'h0, 32'h0, 2'd0, 5'd1, acc_done);
    chk("lat_busy", {bus.m_valid, bus.asi_valid}, 2'b01);
    cycles(1);
    chk("lat_done", {bus.m_valid, bus.m_err}, 2'b10);
    chk("lat_result", bus.m_result, 32'h0);
    cycles(2);

    // four back-to-back SHA3_XY ops, each accepted as its predecessor retires
    exp_resp(32'h0000_0002, 5'd2, 1'b0);
    exp_resp(32'h1D3B_5975, 5'd3, 1'b0);
    exp_resp(32'hFFFF_FFFC, 5'd4, 1'b0);
    exp_resp(32'hFFFF_FFFF, 5'd31, 1'b0);
    issue(UOP_SHA3_XY, 32'h0000_0001, 32'h0000_0002, 2'd1, 5'd2, acc_done);
    issue(UOP_SHA3_XY, 32'h1234_5678, 32'h0F0F_0F0F, 2'd2, 5'd3, acc_done);
    chk("b2b_1_on_retire", acc_done, 1'b1);
    issue(UOP_SHA3_XY, 32'hFFFF_FFFF, 32'h0000_0000, 2'd3, 5'd4, acc_done);
    chk("b2b_2_on_retire", acc_done, 1'b1);
    issue(UOP_SHA3_XY, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'd0, 5'd31, acc_done);
    chk("b2b_3_on_retire", acc_done, 1'b1);
    wait_idle();

    // watchdog: AESSUB never answered -> abort after 15 BUSY cycles
    asi_rdy_en = 1'b0;
    exp_resp(32'h0, 5'd9, 1'b1);
    exp_flush(1'b1, 1'b0, 32'h0);
    issue(UOP_AESSUB, 32'h0000_1111, 32'h0000_2222, 2'd0, 5'd9, acc_done);
    busy_n = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge g_clk);
      if (bus.asi_valid) busy_n++;
      else found = 1'b1;
    end
    chk("wd_busy_cycles", busy_n, 15);
    cycles(5);
    asi_rdy_en = 1'b1;
    wait_idle();

    // kill during AESMIX: back to IDLE, one aesmix pulse with zero data
    asi_rdy_en = 1'b0;
    exp_flush(1'b0, 1'b1, 32'h0);
    issue(UOP_AESMIX, 32'h0BAD_F00D, 32'h1, 2'd0, 5'd11, acc_done);
    cycles(2);
    bus.kill = 1'b1;
    @(negedge g_clk);
    chk("kill_s_ready", bus.s_ready, 1'b0);
    cycles(1);
    bus.kill = 1'b0;
    chk("kill_state", {bus.asi_valid, bus.m_valid}, 2'b00);
    chk("kill_aes_pulse", {bus.asi_flush_aessub, bus.asi_flush_aesmix, bus.asi_flush_data}, {2'b01, 32'h0});
    cycles(1);
    chk("kill_aes_pulse_end", {bus.asi_flush_aessub, bus.asi_flush_aesmix}, 2'b00);
    cycles(3);

    // kill during a non-AES op: no flush pulse
    issue(UOP_SHA256_S1, 32'h5, 32'h6, 2'd0, 5'd12, acc_done);
    cycles(1);
    bus.kill = 1'b1;
    cycles(1);
    bus.kill = 1'b0;
    chk("kill_sha_no_flush", {bus.asi_flush_aessub, bus.asi_flush_aesmix, bus.asi_valid}, 3'b000);
    cycles(2);
    asi_rdy_en = 1'b1;

    // ctx_flush in IDLE: both lines for exactly one cycle with the given data
    exp_flush(1'b1, 1'b1, 32'hDEAD_BEEF);
    bus.ctx_flush = 1'b1; bus.ctx_flush_data = 32'hDEAD_BEEF;
    @(negedge g_clk);
    chk("ctx_s_ready", bus.s_ready, 1'b0);
    cycles(1);
    bus.ctx_flush = 1'b0; bus.ctx_flush_data = 32'h0;
    chk("ctx_pulse", {bus.asi_flush_aessub, bus.asi_flush_aesmix, bus.asi_flush_data}, {2'b11, 32'hDEAD_BEEF});
    cycles(1);
    chk("ctx_pulse_end", {bus.asi_flush_aessub, bus.asi_flush_aesmix}, 2'b00);
    cycles(2);

    // ctx_flush while BUSY aborts the op like kill
    asi_rdy_en = 1'b0;
    exp_flush(1'b1, 1'b1, 32'h1234_5678);
    issue(UOP_SHA3_XY, 32'h7, 32'h8, 2'd1, 5'd13, acc_done);
    cycles(1);
    bus.ctx_flush = 1'b1; bus.ctx_flush_data = 32'h1234_5678;
    cycles(1);
    bus.ctx_flush = 1'b0; bus.ctx_flush_data = 32'h0;
    chk("ctx_busy_abort", {bus.asi_valid, bus.m_valid}, 2'b00);
    cycles(3);
    asi_rdy_en = 1'b1;

    // result held while writeback stalls, then reset clears everything
    bus.m_ready = 1'b0;
    exp_resp(32'hCAFE_BABE, 5'd7, 1'b0);
    issue(UOP_SHA256_S1, 32'hCAFE_0000, 32'h0000_BABE, 2'd0, 5'd7, acc_done);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge g_clk);
      found = bus.m_valid;
    end
    chk("hold_reached_done", found, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge g_clk);
      chk("hold_result", {bus.m_valid, bus.m_rd, bus.m_result}, {1'b1, 5'd7, 32'hCAFE_BABE});
      chk("hold_s_ready", bus.s_ready, 1'b0);
    end
    #2;
    g_resetn = 1'b0;
    #1;
    chk_all_zero("reset_in_done");
    exp_q.delete();
    cycles(2);
    g_resetn = 1'b1;
    bus.m_ready = 1'b1;
    cycles(2);

    // reset mid-BUSY on an AES op: no flush pulse afterwards
    asi_rdy_en = 1'b0;
    issue(UOP_AESSUB, 32'h3, 32'h4, 2'd0, 5'd10, acc_done);
    cycles(2);
    #2;
    g_resetn = 1'b0;
    #1;
    chk_all_zero("reset_in_busy");
    cycles(2);
    g_resetn = 1'b1;
    cycles(3);
    chk("reset_busy_no_flush", {bus.asi_flush_aessub, bus.asi_flush_aesmix, bus.asi_valid}, 3'b000);
    asi_rdy_en = 1'b1;
    cycles(2);

    chk("resp_queue_drained", exp_q.size(), 0);
    chk("flush_queue_drained", fl_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
